// File: rtl/umtrx_tx_err_merge.sv
// UmTRX TX error/ACK stream merge.
// Round-robin packet arbiter joining the 36-bit error streams of two TX chains into one
// registered output stream. Packets are forwarded whole and never interleaved. Each input
// has a wrap-around packet counter, and a sticky flag records a packet whose first word
// did not carry SOF.
//
// Word format: [31:0] payload, [32] SOF, [33] EOF, [35:34] occupancy. Words pass through
// unmodified.

module umtrx_tx_err_merge #(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic                 clear,

   input  logic [35:0]          in0_data,
   input  logic                 in0_valid,
   output logic                 in0_ready,

   input  logic [35:0]          in1_data,
   input  logic                 in1_valid,
   output logic                 in1_ready,

   output logic [35:0]          out_data,
   output logic                 out_valid,
   input  logic                 out_ready,

   output logic [CNT_WIDTH-1:0] pkt_cnt0,
   output logic [CNT_WIDTH-1:0] pkt_cnt1,
   output logic                 framing_err
);

   localparam logic [CNT_WIDTH-1:0] CntOne  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CntZero = '0;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StPkt0 = 2'd1,
      StPkt1 = 2'd2
   } state_e;

   state_e state_q, state_d;

   // Chain that won the most recent arbitration; resets to 1 so chain 0 wins the first tie.
   logic last_q, last_d;

   // High from entry into a packet state until that packet's first word is accepted.
   logic first_q, first_d;

   logic [35:0]          out_data_q, out_data_d;
   logic                 out_valid_q, out_valid_d;
   logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
   logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;
   logic                 ferr_q, ferr_d;

   logic        can_load;
   logic        acc0;
   logic        acc1;
   logic        acc;
   logic [35:0] acc_word;
   logic        acc_sof;
   logic        acc_eof;

   // Handshake decode: the output register can take a word when it is empty or draining.
   always_comb begin
      can_load  = ~out_valid_q | out_ready;
      in0_ready = (state_q == StPkt0) & can_load;
      in1_ready = (state_q == StPkt1) & can_load;
      acc0      = in0_valid & in0_ready;
      acc1      = in1_valid & in1_ready;
      acc       = acc0 | acc1;
      acc_word  = acc1 ? in1_data : in0_data;
      acc_sof   = acc_word[32];
      acc_eof   = acc_word[33];
   end

   // Arbitration and packet-tracking next state.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      first_d = first_q;
      unique case (state_q)
         StIdle: begin
            // Grant costs one bubble cycle; no word moves while idle.
            if (in0_valid && !in1_valid) begin
               state_d = StPkt0;
               last_d  = 1'b0;
               first_d = 1'b1;
            end else if (in1_valid && !in0_valid) begin
               state_d = StPkt1;
               last_d  = 1'b1;
               first_d = 1'b1;
            end else if (in0_valid && in1_valid) begin
               // Tie goes to the chain that did not win last time.
               state_d = last_q ? StPkt0 : StPkt1;
               last_d  = ~last_q;
               first_d = 1'b1;
            end
         end
         StPkt0: begin
            if (acc0) begin
               first_d = 1'b0;
               if (acc_eof) state_d = StIdle;
            end
         end
         StPkt1: begin
            if (acc1) begin
               first_d = 1'b0;
               if (acc_eof) state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Output register: load on accept, drop valid once drained, otherwise hold.
   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      if (acc) begin
         out_data_d  = acc_word;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Packet counters and framing flag; clear overrides a coincident update.
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      ferr_d = ferr_q;
      if (acc0 && acc_eof) cnt0_d = cnt0_q + CntOne;
      if (acc1 && acc_eof) cnt1_d = cnt1_q + CntOne;
      if (acc && first_q && !acc_sof) ferr_d = 1'b1;
      if (clear) begin
         cnt0_d = CntZero;
         cnt1_d = CntZero;
         ferr_d = 1'b0;
      end
   end

   // Arbiter state; a reset mid-packet simply abandons the packet.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= StIdle;
         last_q  <= 1'b1;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         first_q <= first_d;
      end
   end

   // Output word register.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Status counters and sticky error.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt0_q <= CntZero;
         cnt1_q <= CntZero;
         ferr_q <= 1'b0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
         ferr_q <= ferr_d;
      end
   end

   assign out_data    = out_data_q;
   assign out_valid   = out_valid_q;
   assign pkt_cnt0    = cnt0_q;
   assign pkt_cnt1    = cnt1_q;
   assign framing_err = ferr_q;

endmodule

// File: tb/tb_umtrx_tx_err_merge.sv
// Directed bench for umtrx_tx_err_merge. A second, narrow-counter instance shares the
// stimulus so counter wrap-around can be reached in a few packets.

module tb_umtrx_tx_err_merge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic [35:0] in0_data = '0;
   logic        in0_valid = 1'b0;
   logic        in0_ready;
   logic [35:0] in1_data = '0;
   logic        in1_valid = 1'b0;
   logic        in1_ready;
   logic [35:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] pkt_cnt0;
   logic [15:0] pkt_cnt1;
   logic        framing_err;

   logic        w_in0_ready;
   logic        w_in1_ready;
   logic [35:0] w_out_data;
   logic        w_out_valid;
   logic [3:0]  w_pkt_cnt0;
   logic [3:0]  w_pkt_cnt1;
   logic        w_framing_err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   umtrx_tx_err_merge #(.CNT_WIDTH(16)) u_dut (
      .sys_clk     (clk),
      .sys_rst     (rst),
      .clear       (clear),
      .in0_data    (in0_data),
      .in0_valid   (in0_valid),
      .in0_ready   (in0_ready),
      .in1_data    (in1_data),
      .in1_valid   (in1_valid),
      .in1_ready   (in1_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .pkt_cnt0    (pkt_cnt0),
      .pkt_cnt1    (pkt_cnt1),
      .framing_err (framing_err)
   );

   umtrx_tx_err_merge #(.CNT_WIDTH(4)) u_dut_w (
      .sys_clk     (clk),
      .sys_rst     (rst),
      .clear       (clear),
      .in0_data    (in0_data),
      .in0_valid   (in0_valid),
      .in0_ready   (w_in0_ready),
      .in1_data    (in1_data),
      .in1_valid   (in1_valid),
      .in1_ready   (w_in1_ready),
      .out_data    (w_out_data),
      .out_valid   (w_out_valid),
      .out_ready   (out_ready),
      .pkt_cnt0    (w_pkt_cnt0),
      .pkt_cnt1    (w_pkt_cnt1),
      .framing_err (w_framing_err)
   );

   function automatic logic [35:0] mkw(input logic [1:0] occ, input logic sof,
                                       input logic eof, input logic [31:0] p);
      return {occ, eof, sof, p};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Send one packet on chain ch with out_ready held high; each accepted word must appear
   // in the output register right after the accepting edge.
   task automatic send_pkt(input int ch, input int nw, input bit bad_sof, input bit clr_eof,
                           input logic [31:0] base);
      logic [35:0] w;
      bit          done;
      for (int j = 0; j < nw; j++) begin
         w = mkw(2'b01, (j == 0) && !bad_sof, j == nw - 1, base + j);
         if (ch == 0) begin
            in0_valid = 1'b1;
            in0_data  = w;
         end else begin
            in1_valid = 1'b1;
            in1_data  = w;
         end
         done = 1'b0;
         for (int t = 0; t < 20 && !done; t++) begin
            #1;
            if ((ch == 0) ? in0_ready : in1_ready) begin
               if (clr_eof && j == nw - 1) clear = 1'b1;
               done = 1'b1;
            end
            tick();
            clear = 1'b0;
         end
         if (!done) begin
            chk("send_timeout", 64'd0, 64'd1);
         end else begin
            chk("send_ov", out_valid, 1'b1);
            chk("send_od", out_data, w);
         end
      end
      in0_valid = 1'b0;
      in1_valid = 1'b0;
   endtask

   typedef struct {
      logic        v0;
      logic [35:0] d0;
      logic        ordy;
      logic        e_rdy0;
      logic        e_ov;
      logic [35:0] e_od;
   } vec_t;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[6];
      logic [35:0] w0, w1, w2, w3;
      logic [35:0] expq[$];
      logic [35:0] hold, xdata;
      int          n0, n1, r, s;
      bit          a0, a1, stalled, xfer, acc;

      w0 = mkw(2'b00, 1'b1, 1'b0, 32'hA000_0000);
      w1 = mkw(2'b01, 1'b0, 1'b0, 32'hA000_0001);
      w2 = mkw(2'b10, 1'b0, 1'b0, 32'hA000_0002);
      w3 = mkw(2'b11, 1'b0, 1'b1, 32'hA000_0003);
      tbl[0] = '{1'b1, w0, 1'b1, 1'b0, 1'b0, 36'h0};
      tbl[1] = '{1'b1, w0, 1'b1, 1'b1, 1'b1, w0};
      tbl[2] = '{1'b1, w1, 1'b1, 1'b1, 1'b1, w1};
      tbl[3] = '{1'b1, w2, 1'b1, 1'b1, 1'b1, w2};
      tbl[4] = '{1'b1, w3, 1'b1, 1'b1, 1'b1, w3};
      tbl[5] = '{1'b0, 36'h0, 1'b1, 1'b0, 1'b0, w3};

      // Reset state.
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_ov", out_valid, 1'b0);
      chk("rst_od", out_data, 36'h0);
      chk("rst_rdy0", in0_ready, 1'b0);
      chk("rst_rdy1", in1_ready, 1'b0);
      chk("rst_cnt0", pkt_cnt0, 16'h0);
      chk("rst_cnt1", pkt_cnt1, 16'h0);
      chk("rst_ferr", framing_err, 1'b0);
      tick();

      // Four-word packet on chain 0, table driven.
      for (int i = 0; i < 6; i++) begin
         in0_valid = tbl[i].v0;
         in0_data  = tbl[i].d0;
         out_ready = tbl[i].ordy;
         #1;
         chk($sformatf("t2_rdy0[%0d]", i), in0_ready, tbl[i].e_rdy0);
         chk($sformatf("t2_rdy1[%0d]", i), in1_ready, 1'b0);
         tick();
         chk($sformatf("t2_ov[%0d]", i), out_valid, tbl[i].e_ov);
         chk($sformatf("t2_od[%0d]", i), out_data, tbl[i].e_od);
      end
      chk("t2_cnt0", pkt_cnt0, 16'd1);
      chk("t2_ferr", framing_err, 1'b0);

      // Asynchronous reset in the middle of a chain-1 packet.
      in1_valid = 1'b1;
      in1_data  = mkw(2'b00, 1'b1, 1'b0, 32'hB000_0000);
      out_ready = 1'b0;
      tick();
      tick();
      chk("t1_pre_ov", out_valid, 1'b1);
      #2;
      out_ready = 1'b1;
      #1;
      chk("t1_pre_rdy1", in1_ready, 1'b1);
      rst = 1'b1;
      #1;
      chk("t1_ov", out_valid, 1'b0);
      chk("t1_rdy0", in0_ready, 1'b0);
      chk("t1_rdy1", in1_ready, 1'b0);
      chk("t1_cnt0", pkt_cnt0, 16'h0);
      in1_valid = 1'b0;
      tick();
      rst = 1'b0;

      // Both chains present 3-word packets continuously: round robin, one bubble per packet.
      for (int p = 0; p < 4; p++) begin
         for (int j = 0; j < 3; j++) begin
            expq.push_back(mkw(2'b00, j == 0, j == 2,
                               ((p % 2) ? 32'h200 : 32'h100) + (p / 2) * 3 + j));
         end
      end
      n0 = 0;
      n1 = 0;
      for (int k = 0; k < 16; k++) begin
         in0_valid = 1'b1;
         in0_data  = mkw(2'b00, (n0 % 3) == 0, (n0 % 3) == 2, 32'h100 + n0);
         in1_valid = 1'b1;
         in1_data  = mkw(2'b00, (n1 % 3) == 0, (n1 % 3) == 2, 32'h200 + n1);
         #1;
         a0 = in0_ready;
         a1 = in1_ready;
         if (a0 && a1) chk("t3_interleave", 64'd1, 64'd0);
         tick();
         if (a0) n0++;
         if (a1) n1++;
         chk($sformatf("t3_ov[%0d]", k), out_valid, (k % 4) != 0);
         if ((k % 4) != 0 && expq.size() > 0) begin
            chk($sformatf("t3_od[%0d]", k), out_data, expq.pop_front());
         end
      end
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      chk("t3_left", expq.size(), 0);
      chk("t3_cnt0", pkt_cnt0, 16'd2);
      chk("t3_cnt1", pkt_cnt1, 16'd2);
      tick();

      // Backpressure during a chain-1 packet.
      s = 0;
      r = 0;
      for (int c = 0; c < 40 && r < 4; c++) begin
         in1_valid = (s < 4);
         in1_data  = mkw(2'b10, s == 0, s == 3, 32'h300 + s);
         out_ready = (c % 2) == 0;
         #1;
         stalled = out_valid && !out_ready;
         hold    = out_data;
         if (stalled) chk("t4_stall_rdy1", in1_ready, 1'b0);
         chk("t4_rdy0", in0_ready, 1'b0);
         xfer  = out_valid && out_ready;
         xdata = out_data;
         acc   = in1_valid && in1_ready;
         tick();
         if (acc) s++;
         if (xfer) begin
            chk($sformatf("t4_data[%0d]", r), xdata, mkw(2'b10, r == 0, r == 3, 32'h300 + r));
            r++;
         end
         if (stalled) begin
            chk("t4_hold_ov", out_valid, 1'b1);
            chk("t4_hold_od", out_data, hold);
         end
      end
      in1_valid = 1'b0;
      out_ready = 1'b1;
      chk("t4_words", r, 4);
      chk("t4_cnt1", pkt_cnt1, 16'd3);
      tick();

      // Framing error, clear, and clear coinciding with an EOF accept.
      send_pkt(0, 2, 1'b1, 1'b0, 32'h400);
      chk("t5_ferr", framing_err, 1'b1);
      chk("t5_cnt0", pkt_cnt0, 16'd3);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t5_clr_ferr", framing_err, 1'b0);
      chk("t5_clr_cnt0", pkt_cnt0, 16'd0);
      chk("t5_clr_cnt1", pkt_cnt1, 16'd0);
      send_pkt(0, 1, 1'b0, 1'b1, 32'h500);
      chk("t5_clr_eof_cnt0", pkt_cnt0, 16'd0);
      send_pkt(1, 2, 1'b0, 1'b0, 32'h600);
      chk("t5_good_cnt1", pkt_cnt1, 16'd1);
      chk("t5_good_ferr", framing_err, 1'b0);

      // Counter wrap on single-word packets, observed on the narrow instance.
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int i = 0; i < 15; i++) send_pkt(1, 1, 1'b0, 1'b0, 32'h700 + i);
      chk("t6_w_cnt1_max", w_pkt_cnt1, 4'hF);
      chk("t6_cnt1_15", pkt_cnt1, 16'd15);
      send_pkt(1, 1, 1'b0, 1'b0, 32'h7FF);
      chk("t6_w_cnt1_wrap", w_pkt_cnt1, 4'h0);
      chk("t6_cnt1_16", pkt_cnt1, 16'd16);
      chk("t6_w_cnt0", w_pkt_cnt0, 4'h0);
      tick();
      chk("t6_idle_ov", out_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
